// File: rtl/interrupt_ctrl_pkg.sv
// rtl/interrupt_ctrl_pkg.sv - shared state, vector encodings and sequence constants for interrupt_ctrl
package interrupt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RES_HOLD = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SEQ      = 2'd2
    } state_e;

    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_NMI  = 2'b01;
    localparam logic [1:0] VEC_RES  = 2'b10;
    localparam logic [1:0] VEC_IRQ  = 2'b11;

    // Sequence cycle on which BRK6E is asserted; the next ready cycle leaves SEQ.
    localparam logic [2:0] LAST_CYC = 3'd6;

endpackage

// File: rtl/interrupt_ctrl_sync.sv
// rtl/interrupt_ctrl_sync.sv - intr_sync: two-flop synchroniser with configurable reset value
module intr_sync
    import interrupt_ctrl_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous pin; reset parks both stages at the inactive level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - 6502-style RES/NMI/IRQ/BRK sequencer; optional feature macro NMI_HIJACK_EN
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
(
    input  logic       PHI0,
    input  logic       n_RES,
    input  logic       n_NMI,
    input  logic       n_IRQ,
    input  logic       I_FLAG,
    input  logic       n_ready,
    input  logic       T0,
    input  logic       BRK_T1,
    output logic       B_OUT,
    output logic       RESP,
    output logic       DORES,
    output logic       BRK6E,
    output logic [1:0] VEC
);

`ifdef NMI_HIJACK_EN
    // An NMI pending by this cycle can still redirect a BRK/IRQ sequence to the NMI vector.
    localparam logic [2:0] HIJACK_LAST_CYC = 3'd4;
`endif

    state_e     state_q, state_d;
    logic [2:0] cyc_q, cyc_d;
    logic       b_out_q, b_out_d;
    logic [1:0] vec_q, vec_d;
    logic       dores_q, dores_d;
    logic       resp_q;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_prev_q;

    logic       nmi_s;
    logic       irq_s;
    logic       nmi_edge;
    logic       irq_req;
    logic       last_cyc;
    logic       seq_exit;

    intr_sync #(.RST_VAL(1'b1)) u_nmi_sync (
        .clk_i  (PHI0),
        .rst_ni (n_RES),
        .d_i    (n_NMI),
        .q_o    (nmi_s)
    );

    intr_sync #(.RST_VAL(1'b1)) u_irq_sync (
        .clk_i  (PHI0),
        .rst_ni (n_RES),
        .d_i    (n_IRQ),
        .q_o    (irq_s)
    );

    // NMI is edge triggered: only a high-to-low transition of the synchronised pin counts.
    assign nmi_edge = nmi_prev_q & ~nmi_s;
    // IRQ is a live level, masked by the I flag, never latched.
    assign irq_req  = ~irq_s & ~I_FLAG;
    assign last_cyc = (state_q == ST_SEQ) && (cyc_q == LAST_CYC);
    assign seq_exit = last_cyc && !n_ready;

    // NMI edge history and pending flag.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_s;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // Pending NMI is consumed when an NMI-vectored sequence ends; a fresh edge that cycle wins.
    always_comb begin
        nmi_pend_d = nmi_pend_q;
        if (seq_exit && (vec_q == VEC_NMI)) begin
            nmi_pend_d = 1'b0;
        end
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            state_q <= ST_RES_HOLD;
            cyc_q   <= 3'd0;
            b_out_q <= 1'b0;
            vec_q   <= VEC_RES;
            dores_q <= 1'b1;
            resp_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            b_out_q <= b_out_d;
            vec_q   <= vec_d;
            dores_q <= dores_d;
            resp_q  <= 1'b0;
        end
    end

    // Next-state logic; every SEQ change waits for a ready cycle so outputs freeze under stall.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        b_out_d = b_out_q;
        vec_d   = vec_q;
        dores_d = dores_q;
        case (state_q)
            ST_RES_HOLD: begin
                state_d = ST_SEQ;
                cyc_d   = 3'd0;
                b_out_d = 1'b0;
                vec_d   = VEC_RES;
                dores_d = 1'b1;
            end
            ST_IDLE: begin
                if (!n_ready) begin
                    if (T0 && (nmi_pend_q || irq_req)) begin
                        state_d = ST_SEQ;
                        cyc_d   = 3'd1;
                        b_out_d = 1'b0;
                        vec_d   = nmi_pend_q ? VEC_NMI : VEC_IRQ;
                    end else if (BRK_T1) begin
                        state_d = ST_SEQ;
                        cyc_d   = 3'd2;
                        b_out_d = 1'b1;
                        vec_d   = VEC_IRQ;
                    end
                end
            end
            ST_SEQ: begin
                if (!n_ready) begin
                    if (cyc_q == LAST_CYC) begin
                        state_d = ST_IDLE;
                        cyc_d   = 3'd0;
                        b_out_d = 1'b1;
                        vec_d   = VEC_NONE;
                        dores_d = 1'b0;
                    end else begin
                        cyc_d = cyc_q + 3'd1;
`ifdef NMI_HIJACK_EN
                        if ((vec_q == VEC_IRQ) && (cyc_q <= HIJACK_LAST_CYC) && nmi_pend_q) begin
                            vec_d = VEC_NMI;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ST_RES_HOLD;
            end
        endcase
    end

    assign B_OUT = b_out_q;
    assign RESP  = resp_q;
    assign DORES = dores_q;
    assign BRK6E = last_cyc;
    assign VEC   = vec_q;

endmodule
